// File: rtl/aximm_server_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aximm_arb_pkg
// Description : Shared types for the AXI-MM server arbiter: packed payload
//               layouts for each channel, their widths, the controller state
//               encoding and the supported requester count.
// Revision    : 1.0 - initial release
// ============================================================================
package aximm_arb_pkg;

    localparam int MAX_NUM_REQ = 8;

    typedef struct packed {
        logic [7:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [58:0] user;
    } aw_payload_t;

    // Read address carries the same fields as write address.
    typedef aw_payload_t ar_payload_t;

    typedef struct packed {
        logic [7:0]   id;
        logic [511:0] data;
        logic [63:0]  user;
    } w_payload_t;

    typedef struct packed {
        logic [7:0]  id;
        logic [1:0]  resp;
        logic [63:0] user;
    } b_payload_t;

    typedef struct packed {
        logic [7:0]   id;
        logic [511:0] data;
        logic [1:0]   resp;
        logic [63:0]  user;
    } r_payload_t;

    localparam int ARB_AW_W = $bits(aw_payload_t);
    localparam int ARB_W_W  = $bits(w_payload_t);
    localparam int ARB_B_W  = $bits(b_payload_t);
    localparam int ARB_AR_W = $bits(ar_payload_t);
    localparam int ARB_R_W  = $bits(r_payload_t);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WA   = 3'd1,
        ST_WD   = 3'd2,
        ST_WB   = 3'd3,
        ST_RA   = 3'd4,
        ST_RD   = 3'd5
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/aximm_server_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : aximm_server_arbiter_if
// Description : Bundle of requester-side (s_*) and server-side (m_*) AXI-MM
//               channels around the arbiter. Requester payloads are packed
//               per index; B and R payloads are broadcast.
//               Modport slave  : arbiter view.
//               Modport master : environment view (requesters + server).
// Revision    : 1.0 - initial release
// ============================================================================
interface aximm_server_arbiter_if
    import aximm_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int AW_W    = ARB_AW_W,
    parameter int W_W     = ARB_W_W,
    parameter int B_W     = ARB_B_W,
    parameter int AR_W    = ARB_AR_W,
    parameter int R_W     = ARB_R_W
);
    // requester side
    logic [NUM_REQ-1:0]           s_awvalid, s_awready;
    logic [NUM_REQ-1:0][AW_W-1:0] s_awpayload;
    logic [NUM_REQ-1:0]           s_wvalid, s_wready, s_wlast;
    logic [NUM_REQ-1:0][W_W-1:0]  s_wpayload;
    logic [NUM_REQ-1:0]           s_bvalid, s_bready;
    logic [B_W-1:0]               s_bpayload;
    logic [NUM_REQ-1:0]           s_arvalid, s_arready;
    logic [NUM_REQ-1:0][AR_W-1:0] s_arpayload;
    logic [NUM_REQ-1:0]           s_rvalid, s_rready;
    logic                         s_rlast;
    logic [R_W-1:0]               s_rpayload;
    // server side
    logic                         m_awvalid, m_awready;
    logic [AW_W-1:0]              m_awpayload;
    logic                         m_wvalid, m_wready, m_wlast;
    logic [W_W-1:0]               m_wpayload;
    logic                         m_bvalid, m_bready;
    logic [B_W-1:0]               m_bpayload;
    logic                         m_arvalid, m_arready;
    logic [AR_W-1:0]              m_arpayload;
    logic                         m_rvalid, m_rready, m_rlast;
    logic [R_W-1:0]               m_rpayload;

    modport slave (
        input  s_awvalid, s_awpayload, s_wvalid, s_wlast, s_wpayload, s_bready,
               s_arvalid, s_arpayload, s_rready,
        output s_awready, s_wready, s_bvalid, s_bpayload, s_arready, s_rvalid,
               s_rlast, s_rpayload,
        output m_awvalid, m_awpayload, m_wvalid, m_wlast, m_wpayload, m_bready,
               m_arvalid, m_arpayload, m_rready,
        input  m_awready, m_wready, m_bvalid, m_bpayload, m_arready, m_rvalid,
               m_rlast, m_rpayload
    );

    modport master (
        output s_awvalid, s_awpayload, s_wvalid, s_wlast, s_wpayload, s_bready,
               s_arvalid, s_arpayload, s_rready,
        input  s_awready, s_wready, s_bvalid, s_bpayload, s_arready, s_rvalid,
               s_rlast, s_rpayload,
        input  m_awvalid, m_awpayload, m_wvalid, m_wlast, m_wpayload, m_bready,
               m_arvalid, m_arpayload, m_rready,
        output m_awready, m_wready, m_bvalid, m_bpayload, m_arready, m_rvalid,
               m_rlast, m_rpayload
    );

endinterface
`default_nettype wire

// File: rtl/aximm_server_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational requester picker. Scans the request vector
//               starting at ptr_i (wrapping at NUM_REQ) and returns the first
//               hit as one-hot and as an index.
//               AXIMM_ARB_FIXED_PRIO_EN : lowest index wins, ptr_i ignored.
// Ports       : req_i   - request vector
//               ptr_i   - round-robin start index
//               gnt_o   - one-hot winner (0 when no request)
//               idx_o   - winner index
//               valid_o - any request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

`ifdef AXIMM_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr_i;

    always_comb begin
        idx_o = '0;
        // Descending scan so the lowest requesting index is written last.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_i[IDX_W'(k)]) idx_o = IDX_W'(k);
        end
        valid_o = |req_i;
        gnt_o   = '0;
        if (valid_o) gnt_o[idx_o] = 1'b1;
    end
`else
    logic [IDX_W-1:0] cand;

    always_comb begin
        idx_o = '0;
        cand  = '0;
        // Descending offset scan so the hit closest to ptr_i is written last.
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            cand = IDX_W'((int'(ptr_i) + off) % NUM_REQ);
            if (req_i[cand]) idx_o = cand;
        end
        valid_o = |req_i;
        gnt_o   = '0;
        if (valid_o) gnt_o[idx_o] = 1'b1;
    end
`endif

endmodule
`default_nettype wire

// File: rtl/aximm_server_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : aximm_server_arbiter
// Description : Shares one single-transaction AXI-MM server between NUM_REQ
//               requesters. One whole transaction (address, data, response)
//               is granted at a time; channels of the owner are forwarded
//               combinationally, everything else is held at 0.
//               AXIMM_ARB_FIXED_PRIO_EN : fixed priority (lowest index wins)
//               instead of round-robin.
// Ports       : clk, rst - clock, synchronous active-high reset
//               bus      - requester (s_*) and server (m_*) channels
//               busy     - a transaction is in progress
//               grant    - one-hot owner of the current transaction
// Revision    : 1.0 - initial release
// ============================================================================
module aximm_server_arbiter
    import aximm_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int AW_W    = ARB_AW_W,
    parameter int W_W     = ARB_W_W,
    parameter int B_W     = ARB_B_W,
    parameter int AR_W    = ARB_AR_W,
    parameter int R_W     = ARB_R_W
) (
    input  logic                  clk,
    input  logic                  rst,
    aximm_server_arbiter_if.slave bus,
    output logic                  busy,
    output logic [NUM_REQ-1:0]    grant
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    generate
        if (NUM_REQ < 1 || NUM_REQ > MAX_NUM_REQ) begin : g_num_req_check
            $error("aximm_server_arbiter: NUM_REQ out of range");
        end
    endgenerate

    arb_state_e         state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] grant_q;
    logic               busy_q;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    logic [AW_W-1:0] aw_sel;
    logic [W_W-1:0]  w_sel;
    logic [AR_W-1:0] ar_sel;
    logic [B_W-1:0]  b_fwd;
    logic [R_W-1:0]  r_fwd;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_i   (bus.s_awvalid | bus.s_arvalid),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

`ifdef AXIMM_ARB_FIXED_PRIO_EN
    assign ptr_d = '0;
`else
    assign ptr_d = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
`endif

    assign aw_hs = bus.m_awvalid & bus.m_awready;
    assign w_hs  = bus.m_wvalid  & bus.m_wready;
    assign b_hs  = bus.m_bvalid  & bus.m_bready;
    assign ar_hs = bus.m_arvalid & bus.m_arready;
    assign r_hs  = bus.m_rvalid  & bus.m_rready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        idx_q   <= pick_idx;
                        grant_q <= pick_gnt;
                        busy_q  <= 1'b1;
                        // A write beats a read from the same requester.
                        state_q <= bus.s_awvalid[pick_idx] ? ST_WA : ST_RA;
                    end
                end
                ST_WA: if (aw_hs) state_q <= ST_WD;
                ST_WD: if (w_hs && bus.m_wlast) state_q <= ST_WB;
                ST_RA: if (ar_hs) state_q <= ST_RD;
                ST_WB, ST_RD: begin
                    if ((state_q == ST_WB && b_hs) ||
                        (state_q == ST_RD && r_hs && bus.m_rlast)) begin
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        ptr_q   <= ptr_d;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy  = busy_q;
    assign grant = grant_q;

    assign aw_sel = bus.s_awpayload[idx_q];
    assign w_sel  = bus.s_wpayload[idx_q];
    assign ar_sel = bus.s_arpayload[idx_q];
    assign b_fwd  = bus.m_bpayload;
    assign r_fwd  = bus.m_rpayload;

    // Only the channel belonging to the current state is opened, and only
    // toward the owner (grant_q masks the ready/valid fan-out).
    always_comb begin
        bus.m_awvalid   = 1'b0;
        bus.m_awpayload = '0;
        bus.m_wvalid    = 1'b0;
        bus.m_wlast     = 1'b0;
        bus.m_wpayload  = '0;
        bus.m_bready    = 1'b0;
        bus.m_arvalid   = 1'b0;
        bus.m_arpayload = '0;
        bus.m_rready    = 1'b0;
        bus.s_awready   = '0;
        bus.s_wready    = '0;
        bus.s_bvalid    = '0;
        bus.s_bpayload  = '0;
        bus.s_arready   = '0;
        bus.s_rvalid    = '0;
        bus.s_rlast     = 1'b0;
        bus.s_rpayload  = '0;
        case (state_q)
            ST_WA: begin
                bus.m_awvalid   = bus.s_awvalid[idx_q];
                bus.m_awpayload = aw_sel;
                bus.s_awready   = grant_q & {NUM_REQ{bus.m_awready}};
            end
            ST_WD: begin
                bus.m_wvalid   = bus.s_wvalid[idx_q];
                bus.m_wlast    = bus.s_wlast[idx_q];
                bus.m_wpayload = w_sel;
                bus.s_wready   = grant_q & {NUM_REQ{bus.m_wready}};
            end
            ST_WB: begin
                bus.m_bready   = bus.s_bready[idx_q];
                bus.s_bvalid   = grant_q & {NUM_REQ{bus.m_bvalid}};
                bus.s_bpayload = b_fwd;
            end
            ST_RA: begin
                bus.m_arvalid   = bus.s_arvalid[idx_q];
                bus.m_arpayload = ar_sel;
                bus.s_arready   = grant_q & {NUM_REQ{bus.m_arready}};
            end
            ST_RD: begin
                bus.m_rready   = bus.s_rready[idx_q];
                bus.s_rvalid   = grant_q & {NUM_REQ{bus.m_rvalid}};
                bus.s_rlast    = bus.m_rlast;
                bus.s_rpayload = r_fwd;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_aximm_server_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_aximm_server_arbiter
// Description : Random requesters and a random server drive the arbiter;
//               a transaction-level reference (owner, progress flags,
//               round-robin pointer) predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aximm_server_arbiter;
    import aximm_arb_pkg::*;

    localparam int N      = 3;
    localparam int AWW    = ARB_AW_W;
    localparam int WW     = ARB_W_W;
    localparam int BW     = ARB_B_W;
    localparam int ARW    = ARB_AR_W;
    localparam int RW     = ARB_R_W;
    localparam int CYCLES = 3000;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic [N-1:0] grant;

    always #5 clk = ~clk;

    aximm_server_arbiter_if #(.NUM_REQ(N), .AW_W(AWW), .W_W(WW), .B_W(BW),
                              .AR_W(ARW), .R_W(RW)) bus ();

    aximm_server_arbiter #(.NUM_REQ(N), .AW_W(AWW), .W_W(WW), .B_W(BW),
                           .AR_W(ARW), .R_W(RW)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .busy  (busy),
        .grant (grant)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // reference model
    int m_owner;
    int m_ptr;
    bit m_wr, m_addr_done, m_data_done;
    // handshakes predicted for the current cycle
    bit hs_aw, hs_w, hs_b, hs_ar, hs_r, x_wlast, x_rlast;
    // requester agents
    bit wr_busy [N];
    bit rd_busy [N];
    int beats_left [N];
    // server agent
    bit b_owed;
    int r_beats;

    task automatic chk_eq(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [639:0] rnd640();
        logic [639:0] v;
        for (int k = 0; k < 20; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int pick(input logic [N-1:0] cand, input int ptr);
`ifdef AXIMM_ARB_FIXED_PRIO_EN
        for (int k = 0; k < N; k++) if (cand[k]) return k;
`else
        for (int off = 0; off < N; off++) if (cand[(ptr + off) % N]) return (ptr + off) % N;
`endif
        return -1;
    endfunction

    // Predict all outputs from the model and the current inputs, compare.
    task automatic check_cycle();
        logic e_busy, e_awv, e_wv, e_wl, e_bry, e_arv, e_rry, e_rl;
        logic [N-1:0] e_grant, e_awr, e_wr, e_bv, e_arr, e_rv;
        logic [AWW-1:0] e_awp;
        logic [WW-1:0]  e_wp;
        logic [BW-1:0]  e_bp;
        logic [ARW-1:0] e_arp;
        logic [RW-1:0]  e_rp;
        int o;
        o = m_owner;
        e_busy = (o >= 0);
        {e_awv, e_wv, e_wl, e_bry, e_arv, e_rry, e_rl} = '0;
        {e_grant, e_awr, e_wr, e_bv, e_arr, e_rv} = '0;
        e_awp = '0; e_wp = '0; e_bp = '0; e_arp = '0; e_rp = '0;
        if (o >= 0) begin
            e_grant[o] = 1'b1;
            if (m_wr && !m_addr_done) begin
                e_awv = bus.s_awvalid[o]; e_awp = bus.s_awpayload[o]; e_awr[o] = bus.m_awready;
            end else if (m_wr && !m_data_done) begin
                e_wv = bus.s_wvalid[o]; e_wl = bus.s_wlast[o]; e_wp = bus.s_wpayload[o];
                e_wr[o] = bus.m_wready;
            end else if (m_wr) begin
                e_bv[o] = bus.m_bvalid; e_bry = bus.s_bready[o]; e_bp = bus.m_bpayload;
            end else if (!m_addr_done) begin
                e_arv = bus.s_arvalid[o]; e_arp = bus.s_arpayload[o]; e_arr[o] = bus.m_arready;
            end else begin
                e_rv[o] = bus.m_rvalid; e_rry = bus.s_rready[o]; e_rl = bus.m_rlast;
                e_rp = bus.m_rpayload;
            end
        end
        chk_eq("busy_grant", {busy, grant}, {e_busy, e_grant});
        chk_eq("ctl",
               {bus.m_awvalid, bus.m_wvalid, bus.m_wlast, bus.m_bready, bus.m_arvalid,
                bus.m_rready, bus.s_rlast, bus.s_awready, bus.s_wready, bus.s_bvalid,
                bus.s_arready, bus.s_rvalid},
               {e_awv, e_wv, e_wl, e_bry, e_arv, e_rry, e_rl, e_awr, e_wr, e_bv, e_arr, e_rv});
        chk_eq("m_awpayload", bus.m_awpayload, e_awp);
        chk_eq("m_wpayload",  bus.m_wpayload,  e_wp);
        chk_eq("m_arpayload", bus.m_arpayload, e_arp);
        chk_eq("s_bpayload",  bus.s_bpayload,  e_bp);
        chk_eq("s_rpayload",  bus.s_rpayload,  e_rp);
        hs_aw   = e_awv & bus.m_awready;
        hs_w    = e_wv & bus.m_wready;
        hs_b    = (o >= 0) && e_bv[o] && e_bry;
        hs_ar   = e_arv & bus.m_arready;
        hs_r    = (o >= 0) && e_rv[o] && e_rry;
        x_wlast = e_wl;
        x_rlast = e_rl;
    endtask

    task automatic reset_agents();
        for (int i = 0; i < N; i++) begin
            wr_busy[i] = 1'b0; rd_busy[i] = 1'b0; beats_left[i] = 0;
        end
        b_owed = 1'b0; r_beats = 0;
        bus.s_awvalid = '0; bus.s_wvalid = '0; bus.s_wlast = '0; bus.s_arvalid = '0;
        bus.s_bready = '0; bus.s_rready = '0;
        bus.s_awpayload = '0; bus.s_wpayload = '0; bus.s_arpayload = '0;
        bus.m_awready = 1'b0; bus.m_wready = 1'b0; bus.m_arready = 1'b0;
        bus.m_bvalid = 1'b0; bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0;
        bus.m_bpayload = '0; bus.m_rpayload = '0;
    endtask

    // Called just after a clock edge: inputs still hold their edge values.
    task automatic advance();
        int o;
        logic [639:0] t;
        o = m_owner;
        if (rst) begin
            m_owner = -1; m_ptr = 0;
            reset_agents();
        end else begin
            if (o < 0) begin
                m_owner = pick(bus.s_awvalid | bus.s_arvalid, m_ptr);
                if (m_owner >= 0) begin
                    m_wr = bus.s_awvalid[m_owner];
                    m_addr_done = 1'b0; m_data_done = 1'b0;
                end
            end else begin
                if (hs_aw || hs_ar) m_addr_done = 1'b1;
                if (hs_w && x_wlast) m_data_done = 1'b1;
                if (hs_b || (hs_r && x_rlast)) begin
`ifdef AXIMM_ARB_FIXED_PRIO_EN
                    m_ptr = 0;
`else
                    m_ptr = (o + 1) % N;
`endif
                    m_owner = -1;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (o == i && hs_aw) bus.s_awvalid[i] = 1'b0;
                if (o == i && hs_w) begin
                    beats_left[i]--; bus.s_wvalid[i] = 1'b0; bus.s_wlast[i] = 1'b0;
                end
                if (o == i && hs_b) wr_busy[i] = 1'b0;
                if (o == i && hs_ar) bus.s_arvalid[i] = 1'b0;
                if (o == i && hs_r && x_rlast) rd_busy[i] = 1'b0;
                if (!wr_busy[i] && $urandom_range(0, 3) == 0) begin
                    wr_busy[i] = 1'b1; bus.s_awvalid[i] = 1'b1;
                    t = rnd640(); bus.s_awpayload[i] = t[AWW-1:0];
                    beats_left[i] = $urandom_range(1, 4);
                end
                // W may be offered before its AW is accepted.
                if (beats_left[i] > 0 && !bus.s_wvalid[i] && $urandom_range(0, 2) != 0) begin
                    bus.s_wvalid[i] = 1'b1; bus.s_wlast[i] = (beats_left[i] == 1);
                    t = rnd640(); bus.s_wpayload[i] = t[WW-1:0];
                end
                if (!rd_busy[i] && $urandom_range(0, 3) == 0) begin
                    rd_busy[i] = 1'b1; bus.s_arvalid[i] = 1'b1;
                    t = rnd640(); bus.s_arpayload[i] = t[ARW-1:0];
                end
                bus.s_bready[i] = ($urandom_range(0, 3) != 0);
                bus.s_rready[i] = ($urandom_range(0, 3) != 0);
            end
            bus.m_awready = ($urandom_range(0, 3) != 0);
            bus.m_wready  = ($urandom_range(0, 3) != 0);
            bus.m_arready = ($urandom_range(0, 3) != 0);
            if (hs_w && x_wlast) b_owed = 1'b1;
            if (hs_b) begin b_owed = 1'b0; bus.m_bvalid = 1'b0; end
            if (b_owed && !bus.m_bvalid && $urandom_range(0, 1) == 1) begin
                bus.m_bvalid = 1'b1; t = rnd640(); bus.m_bpayload = t[BW-1:0];
            end
            if (hs_ar) r_beats = $urandom_range(1, 4);
            if (hs_r) begin r_beats--; bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0; end
            if (r_beats > 0 && !bus.m_rvalid && $urandom_range(0, 2) != 0) begin
                bus.m_rvalid = 1'b1; bus.m_rlast = (r_beats == 1);
                t = rnd640(); bus.m_rpayload = t[RW-1:0];
            end
        end
        // Occasional reset in the middle of a transaction.
        rst = (cyc > 100) && (m_owner >= 0) && ($urandom_range(0, 199) == 0);
    endtask

    initial begin
        rst = 1'b1;
        m_owner = -1; m_ptr = 0;
        m_wr = 1'b0; m_addr_done = 1'b0; m_data_done = 1'b0;
        {hs_aw, hs_w, hs_b, hs_ar, hs_r, x_wlast, x_rlast} = '0;
        reset_agents();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < CYCLES; c++) begin
            cyc = c;
            @(negedge clk);
            check_cycle();
            @(posedge clk);
            #1;
            advance();
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
